// File: rtl/sega_pad_pkg.sv
// rtl/sega_pad_pkg.sv - phase codes, word bit positions and helpers for the DB9 pad scanner
package sega_pad_pkg;

    typedef enum logic [2:0] {
        PH_SEL_LO0    = 3'd0,
        PH_SEL_HI0    = 3'd1,
        PH_SAMPLE_HI  = 3'd2,
        PH_SAMPLE_LO  = 3'd3,
        PH_SEL_LO2    = 3'd4,
        PH_SAMPLE_ID  = 3'd5,
        PH_SAMPLE_EXT = 3'd6,
        PH_COMMIT     = 3'd7
    } phase_e;

    localparam int IDX_U = 0;
    localparam int IDX_D = 1;
    localparam int IDX_L = 2;
    localparam int IDX_R = 3;
    localparam int IDX_B = 4;
    localparam int IDX_C = 5;
    localparam int IDX_A = 6;
    localparam int IDX_S = 7;
    localparam int IDX_Z = 8;
    localparam int IDX_Y = 9;
    localparam int IDX_X = 10;
    localparam int IDX_M = 11;

    localparam int ACTIVE_PHASES = 8;

    typedef logic [11:0] pad_word_t;

    localparam pad_word_t PAD_IDLE = 12'hFFF;

    // Select level left on the line after a frame phase's action:
    // even phases pull it low, odd phases release it high.
    function automatic logic sel_level(input logic [2:0] ph);
        return ph[0];
    endfunction

endpackage

// File: rtl/sega_pad_port.sv
// rtl/sega_pad_port.sv - per-port pin synchroniser, shadow word and 6-button detection
module sega_pad_port
    import sega_pad_pkg::*;
(
    input  logic        clk_i,
    input  logic        res_n_i,
    input  logic        act_i,
    input  logic [2:0]  phase_i,
    input  logic [5:0]  pins_i,
    output logic [11:0] shadow_o,
    output logic        six_o
);

    logic [5:0] meta_q;
    logic [5:0] sync_q;
    logic [3:0] dirs;
    logic       p6;
    logic       p9;

    pad_word_t  shadow_q;
    pad_word_t  shadow_d;
    logic       tent_q;
    logic       tent_d;

    // Pins idle high, so the synchroniser resets to the released state.
    always_ff @(posedge clk_i or negedge res_n_i) begin
        if (!res_n_i) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= pins_i;
            sync_q <= meta_q;
        end
    end

    assign dirs = sync_q[3:0];
    assign p6   = sync_q[4];
    assign p9   = sync_q[5];

    always_comb begin
        shadow_d = shadow_q;
        tent_d   = tent_q;
        if (act_i) begin
            unique case (phase_e'(phase_i))
                PH_SAMPLE_HI: begin
                    shadow_d[IDX_R:IDX_U] = dirs;
                    shadow_d[IDX_C:IDX_B] = {p9, p6};
                    tent_d                = 1'b0;
                end
                PH_SAMPLE_LO: begin
                    // Left+right both low only happens on a Mega Drive pad with select low.
                    if (!dirs[IDX_R] && !dirs[IDX_L]) begin
                        shadow_d[IDX_S:IDX_A] = {p9, p6};
                    end else begin
                        shadow_d[IDX_S:IDX_B] = {2'b11, p9, p6};
                    end
                end
                PH_SAMPLE_ID: begin
                    if (dirs == 4'b0000) begin
                        tent_d = 1'b1;
                    end
                end
                PH_SAMPLE_EXT: begin
                    shadow_d[IDX_M:IDX_Z] = tent_q ? dirs : 4'b1111;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge res_n_i) begin
        if (!res_n_i) begin
            shadow_q <= PAD_IDLE;
            tent_q   <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            tent_q   <= tent_d;
        end
    end

    assign shadow_o = shadow_q;
    assign six_o    = tent_q;

endmodule

// File: rtl/sega_pad_scanner.sv
// rtl/sega_pad_scanner.sv - phase sequencer, select line and double-buffered commit for two DB9 ports
module sega_pad_scanner
    import sega_pad_pkg::*;
#(
    parameter int TICK_DIV     = 64,
    parameter int FRAME_PHASES = 256
)
(
    input  logic        clk_i,
    input  logic        res_n_i,
    input  logic        scan_en_i,
    input  logic [5:0]  joy1_pins_i,
    input  logic [5:0]  joy2_pins_i,
    output logic        p7_o,
    output logic [11:0] joy1_o,
    output logic [11:0] joy2_o,
    output logic        joy1_six_o,
    output logic        joy2_six_o,
    output logic        frame_valid_o
);

    localparam int CW = $clog2(TICK_DIV);
    localparam int PW = $clog2(FRAME_PHASES);

    logic [CW-1:0] presc_q;
    logic [CW-1:0] presc_d;
    logic [PW-1:0] phase_q;
    logic [PW-1:0] phase_d;
    logic          p7_q;
    logic          p7_d;

    logic          tick;
    logic          in_frame;
    logic          act;
    logic          commit;
    logic [2:0]    act_phase;

    pad_word_t     shadow1;
    pad_word_t     shadow2;
    logic          tent1;
    logic          tent2;

    pad_word_t     joy1_q;
    pad_word_t     joy2_q;
    logic          six1_q;
    logic          six2_q;
    logic          frame_valid_q;

    always_ff @(posedge clk_i or negedge res_n_i) begin
        if (!res_n_i) begin
            presc_q <= '0;
            phase_q <= '0;
            p7_q    <= 1'b1;
        end else begin
            presc_q <= presc_d;
            phase_q <= phase_d;
            p7_q    <= p7_d;
        end
    end

    always_comb begin
        presc_d = presc_q;
        phase_d = phase_q;
        p7_d    = p7_q;
        if (!scan_en_i) begin
            presc_d = '0;
            phase_d = '0;
            p7_d    = 1'b1;
        end else if (tick) begin
            presc_d = '0;
            phase_d = (phase_q == PW'(FRAME_PHASES - 1)) ? '0 : phase_q + 1'b1;
            // Idle phases keep select high so the 6-button pad's edge counter times out.
            p7_d    = in_frame ? sel_level(act_phase) : 1'b1;
        end else begin
            presc_d = presc_q + 1'b1;
        end
    end

    always_comb begin
        tick      = scan_en_i && (presc_q == CW'(TICK_DIV - 1));
        in_frame  = (32'(phase_q) < 32'(ACTIVE_PHASES));
        act_phase = phase_q[2:0];
        act       = tick && in_frame;
        commit    = act && (phase_e'(act_phase) == PH_COMMIT);
    end

    sega_pad_port u_port1 (
        .clk_i    (clk_i),
        .res_n_i  (res_n_i),
        .act_i    (act),
        .phase_i  (act_phase),
        .pins_i   (joy1_pins_i),
        .shadow_o (shadow1),
        .six_o    (tent1)
    );

    sega_pad_port u_port2 (
        .clk_i    (clk_i),
        .res_n_i  (res_n_i),
        .act_i    (act),
        .phase_i  (act_phase),
        .pins_i   (joy2_pins_i),
        .shadow_o (shadow2),
        .six_o    (tent2)
    );

    // Published words move only at commit, so consumers never see a half-scanned frame.
    always_ff @(posedge clk_i or negedge res_n_i) begin
        if (!res_n_i) begin
            joy1_q        <= PAD_IDLE;
            joy2_q        <= PAD_IDLE;
            six1_q        <= 1'b0;
            six2_q        <= 1'b0;
            frame_valid_q <= 1'b0;
        end else begin
            frame_valid_q <= commit;
            if (commit) begin
                joy1_q <= shadow1;
                joy2_q <= shadow2;
                six1_q <= tent1;
                six2_q <= tent2;
            end
        end
    end

    assign p7_o          = p7_q;
    assign joy1_o        = joy1_q;
    assign joy2_o        = joy2_q;
    assign joy1_six_o    = six1_q;
    assign joy2_six_o    = six2_q;
    assign frame_valid_o = frame_valid_q;

endmodule

// File: tb/tb_sega_pad_scanner.sv
// tb/tb_sega_pad_scanner.sv - directed bench for sega_pad_scanner with SMS, 3-button and 6-button pad models
module tb_sega_pad_scanner;

    localparam int TD        = 8;
    localparam int FP        = 16;
    localparam int FRAME_CYC = TD * FP;
    localparam int PAD_TMO   = 20;

    logic        clk     = 1'b0;
    logic        res_n   = 1'b0;
    logic        scan_en = 1'b1;
    logic [5:0]  joy1_pins;
    logic [5:0]  joy2_pins;
    logic        p7;
    logic [11:0] joy1;
    logic [11:0] joy2;
    logic        six1;
    logic        six2;
    logic        fv;

    // mode: 0 raw pins, 2 three-button pad, 3 six-button pad
    int          mode1 = 0;
    int          mode2 = 3;
    logic [5:0]  raw1  = 6'b101110;
    logic [5:0]  raw2  = 6'h3F;
    logic [11:0] btn1  = 12'hFFF;
    logic [11:0] btn2  = 12'hE7F;

    logic        p7_d   = 1'b1;
    int          hi_cnt = 0;
    int          falls  = 0;

    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    sega_pad_scanner #(
        .TICK_DIV     (TD),
        .FRAME_PHASES (FP)
    ) dut (
        .clk_i         (clk),
        .res_n_i       (res_n),
        .scan_en_i     (scan_en),
        .joy1_pins_i   (joy1_pins),
        .joy2_pins_i   (joy2_pins),
        .p7_o          (p7),
        .joy1_o        (joy1),
        .joy2_o        (joy2),
        .joy1_six_o    (six1),
        .joy2_six_o    (six2),
        .frame_valid_o (fv)
    );

    // Pad-side select edge counter with idle timeout, as inside a 6-button pad.
    always @(posedge clk) begin
        p7_d <= p7;
        if (p7_d && !p7) falls <= falls + 1;
        else if (p7 && hi_cnt >= PAD_TMO) falls <= 0;
        hi_cnt <= p7 ? hi_cnt + 1 : 0;
    end

    function automatic logic [5:0] pad_pins(input int mode, input logic [5:0] raw,
                                            input logic [11:0] b, input logic sel, input int n);
        case (mode)
            2: return sel ? {b[5], b[4], b[3:0]} : {b[7], b[6], 2'b00, b[1:0]};
            3: begin
                if (sel) return (n == 3) ? {b[5], b[4], b[11:8]} : {b[5], b[4], b[3:0]};
                else if (n == 3) return {b[7], b[6], 4'b0000};
                else if (n >= 4) return {b[7], b[6], 4'b1111};
                else return {b[7], b[6], 2'b00, b[1:0]};
            end
            default: return raw;
        endcase
    endfunction

    assign joy1_pins = pad_pins(mode1, raw1, btn1, p7, falls);
    assign joy2_pins = pad_pins(mode2, raw2, btn2, p7, falls);

    task automatic wait_fv(input int max_cyc, output bit found);
        int cyc;
        found = 1'b0;
        cyc = 0;
        while (!found && cyc < max_cyc) begin
            @(posedge clk); #1;
            cyc++;
            if (fv === 1'b1) found = 1'b1;
        end
    endtask

    task automatic test_reset();
        int k;
        res_n = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        total++; if (p7 !== 1'b1) begin bad++; $display("FAIL reset_p7: got %b want 1", p7); end
        total++; if (joy1 !== 12'hFFF) begin bad++; $display("FAIL reset_joy1: got %h want fff", joy1); end
        total++; if (joy2 !== 12'hFFF) begin bad++; $display("FAIL reset_joy2: got %h want fff", joy2); end
        total++; if ({six1, six2} !== 2'b00) begin bad++; $display("FAIL reset_six: got %b want 00", {six1, six2}); end
        total++; if (fv !== 1'b0) begin bad++; $display("FAIL reset_fv: got %b want 0", fv); end
        @(negedge clk); res_n = 1'b1;
        k = 0;
        while (p7 !== 1'b0 && k < 4 * TD) begin @(posedge clk); #1; k++; end
        total++; if (k != TD) begin bad++; $display("FAIL reset_first_tick: got %0d clocks want %0d", k, TD); end
    endtask

    task automatic test_sms();
        bit found;
        wait_fv(2 * FRAME_CYC, found);
        total++; if (!found) begin bad++; $display("FAIL sms_commit: got none want frame_valid"); end
        total++; if (joy1 !== 12'hFEE) begin bad++; $display("FAIL sms_joy1: got %h want fee", joy1); end
        total++; if (six1 !== 1'b0) begin bad++; $display("FAIL sms_six1: got %b want 0", six1); end
        total++; if (p7 !== 1'b1) begin bad++; $display("FAIL sms_commit_p7: got %b want 1", p7); end
        @(posedge clk); #1;
        total++; if (fv !== 1'b0) begin bad++; $display("FAIL sms_fv_width: got %b want 0", fv); end
    endtask

    task automatic test_six_button();
        bit found;
        wait_fv(2 * FRAME_CYC, found);
        total++; if (!found) begin bad++; $display("FAIL six_commit: got none want frame_valid"); end
        total++; if (joy2 !== 12'hE7F) begin bad++; $display("FAIL six_joy2: got %h want e7f", joy2); end
        total++; if (six2 !== 1'b1) begin bad++; $display("FAIL six_flag2: got %b want 1", six2); end
        total++; if (joy1 !== 12'hFEE) begin bad++; $display("FAIL six_joy1_hold: got %h want fee", joy1); end
    endtask

    task automatic test_three_button();
        bit found;
        mode1 = 2;
        btn1  = 12'hFBF;
        wait_fv(2 * FRAME_CYC, found);
        total++; if (!found) begin bad++; $display("FAIL three_commit: got none want frame_valid"); end
        total++; if (joy1 !== 12'hFBF) begin bad++; $display("FAIL three_joy1: got %h want fbf", joy1); end
        total++; if (six1 !== 1'b0) begin bad++; $display("FAIL three_six1: got %b want 0", six1); end
    endtask

    task automatic test_mid_frame_change();
        bit found;
        int cyc;
        int glitches;
        repeat (12 * TD + 2) @(posedge clk);
        #1;
        mode1 = 0;
        raw1  = 6'h3F;
        found = 1'b0;
        cyc = 0;
        glitches = 0;
        while (!found && cyc < 2 * FRAME_CYC) begin
            @(posedge clk); #1;
            cyc++;
            if (fv === 1'b1) found = 1'b1;
            else if (joy1 !== 12'hFBF) glitches++;
        end
        total++; if (!found) begin bad++; $display("FAIL mid_commit: got none want frame_valid"); end
        total++; if (glitches != 0) begin bad++; $display("FAIL mid_stable: got %0d changed cycles want 0", glitches); end
        total++; if (joy1 !== 12'hFBF) begin bad++; $display("FAIL mid_mixed_word: got %h want fbf", joy1); end
        wait_fv(2 * FRAME_CYC, found);
        total++; if (!found) begin bad++; $display("FAIL mid_commit2: got none want frame_valid"); end
        total++; if (joy1 !== 12'hFFF) begin bad++; $display("FAIL mid_disconnected: got %h want fff", joy1); end
        total++; if (six1 !== 1'b0) begin bad++; $display("FAIL mid_six1: got %b want 0", six1); end
    endtask

    task automatic test_scan_disable();
        int fv_seen;
        int changed;
        int k;
        repeat (11 * TD + 2) @(posedge clk);
        #1;
        total++; if (p7 !== 1'b0) begin bad++; $display("FAIL dis_phase3_p7: got %b want 0", p7); end
        scan_en = 1'b0;
        @(posedge clk); #1;
        total++; if (p7 !== 1'b1) begin bad++; $display("FAIL dis_p7_high: got %b want 1", p7); end
        fv_seen = 0;
        changed = 0;
        repeat (3 * FRAME_CYC) begin
            @(posedge clk); #1;
            if (fv !== 1'b0) fv_seen++;
            if (joy1 !== 12'hFFF || joy2 !== 12'hE7F || six2 !== 1'b1 || p7 !== 1'b1) changed++;
        end
        total++; if (fv_seen != 0) begin bad++; $display("FAIL dis_no_fv: got %0d pulses want 0", fv_seen); end
        total++; if (changed != 0) begin bad++; $display("FAIL dis_hold: got %0d changed cycles want 0", changed); end
        @(negedge clk); scan_en = 1'b1;
        k = 0;
        while (fv !== 1'b1 && k < 20 * TD) begin @(posedge clk); #1; k++; end
        total++; if (k != 8 * TD) begin bad++; $display("FAIL dis_restart_latency: got %0d clocks want %0d", k, 8 * TD); end
        total++; if (joy2 !== 12'hE7F) begin bad++; $display("FAIL dis_restart_joy2: got %h want e7f", joy2); end
    endtask

    task automatic test_reset_mid_frame();
        bit found;
        int k;
        repeat (13 * TD + 2) @(posedge clk);
        #2;
        res_n = 1'b0;
        #1;
        total++; if (joy1 !== 12'hFFF) begin bad++; $display("FAIL rst_mid_joy1: got %h want fff", joy1); end
        total++; if (joy2 !== 12'hFFF) begin bad++; $display("FAIL rst_mid_joy2: got %h want fff", joy2); end
        total++; if (six2 !== 1'b0) begin bad++; $display("FAIL rst_mid_six2: got %b want 0", six2); end
        total++; if (p7 !== 1'b1) begin bad++; $display("FAIL rst_mid_p7: got %b want 1", p7); end
        repeat (30) @(posedge clk);
        #1;
        total++; if (fv !== 1'b0 || joy2 !== 12'hFFF) begin bad++; $display("FAIL rst_mid_hold: got fv=%b joy2=%h want fv=0 joy2=fff", fv, joy2); end
        @(negedge clk); res_n = 1'b1;
        k = 0;
        while (p7 !== 1'b0 && k < 4 * TD) begin @(posedge clk); #1; k++; end
        total++; if (k != TD) begin bad++; $display("FAIL rst_mid_first_tick: got %0d clocks want %0d", k, TD); end
        wait_fv(2 * FRAME_CYC, found);
        total++; if (!found) begin bad++; $display("FAIL rst_mid_commit: got none want frame_valid"); end
        total++; if (joy2 !== 12'hE7F || six2 !== 1'b1) begin bad++; $display("FAIL rst_mid_joy2_after: got %h/%b want e7f/1", joy2, six2); end
    endtask

    initial begin
        test_reset();
        test_sms();
        test_six_button();
        test_three_button();
        test_mid_frame_change();
        test_scan_disable();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
